// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA pushes into a FIFO, bytes go out LSB first on tx.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  memWMask,
    input  logic [31:0] addr,
    input  logic [31:0] memWdata,
    output logic [31:0] memRdata,
    output logic        hit,
    output logic        tx,
    output logic        busy
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
    state_e state_q, state_d;

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic [3:0]      count_field;
    logic            overflow_q;
    logic [15:0]     bauddiv_q, bauddiv_new;
    logic [15:0]     div_q, baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            full, empty, push, pop, bit_end, tx_active;
    logic            wr_txdata, wr_status, wr_baud_lo, wr_baud_hi;
    logic            unused_wdata;

    assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata  = hit && (addr[3:0] == 4'h0) && memWMask[0];
    assign wr_status  = hit && (addr[3:0] == 4'h4) && memWMask[0];
    assign wr_baud_lo = hit && (addr[3:0] == 4'h8) && memWMask[0];
    assign wr_baud_hi = hit && (addr[3:0] == 4'h8) && memWMask[1];
    assign unused_wdata = ^{memWdata[31:16], memWMask[3:2]};

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = wr_txdata && (!full || pop);
    assign busy  = !empty || tx_active;
    assign count_field = 4'(count_q);
    assign bit_end = (baud_cnt_q == div_q - 16'd1);

    assign bauddiv_new = {wr_baud_hi ? memWdata[15:8] : bauddiv_q[15:8],
                          wr_baud_lo ? memWdata[7:0]  : bauddiv_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bauddiv_q  <= DEFAULT_DIV;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (wr_txdata && full && !pop) overflow_q <= 1'b1;
            else if (wr_status && memWdata[3]) overflow_q <= 1'b0;
            if (wr_baud_lo || wr_baud_hi) begin
                bauddiv_q <= (bauddiv_new == 16'd0) ? 16'd1 : bauddiv_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= memWdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Leaving STOP with data queued pops directly so frames run back to back.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: if (!empty) begin
                state_d = StStart;
                pop     = 1'b1;
            end
            StStart: if (bit_end) state_d = StData;
            StData: if (bit_end && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = StParity;
`else
                state_d = StStop;
`endif
            end
            StParity: if (bit_end) state_d = StStop;
            StStop: if (bit_end) begin
                if (!empty) begin
                    state_d = StStart;
                    pop     = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx        = 1'b1;
        tx_active = 1'b1;
        unique case (state_q)
            StIdle:   tx_active = 1'b0;
            StStart:  tx = 1'b0;
            StData:   tx = shift_q[0];
            StParity: tx = parity_q;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            div_q      <= DEFAULT_DIV;
        end else if (pop) begin
            shift_q    <= fifo_q[rptr_q];
            parity_q   <= ^fifo_q[rptr_q];
            div_q      <= bauddiv_q;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (state_q != StIdle) begin
            if (bit_end) begin
                baud_cnt_q <= '0;
                if (state_q == StData) begin
                    shift_q   <= {1'b0, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else begin
                baud_cnt_q <= baud_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        memRdata = '0;
        if (hit) begin
            case (addr[3:0])
                4'h4: memRdata = {20'd0, count_field, 4'd0, overflow_q, tx_active, empty, full};
                4'h8: memRdata = {16'd0, bauddiv_q};
                default: memRdata = '0;
            endcase
        end
    end
endmodule
